updown_count_sched: RTL and testbench

Controller and two-port arbiter for the shared WIDTH-bit up/down counter.
- Accepts run requests from two requesters and grants the counter round-robin.
- Initialises the counter (clear for up runs, preset for down runs), then enables it for exactly the requested number of steps.
- Checks the final count and pulses done to the winning requester.
- Sits between the requesting control logic and the counter's reset/preset/mode/enable pins; the counter's count output feeds back into the block.

---
 rtl/updown_count_sched.sv | 201 ++++++++++++++++++++
 tb/tb_updown_count_sched.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/updown_count_sched.sv
`default_nettype none
// ============================================================================
// Module      : updown_count_sched
// Description : Controller and two-port round-robin arbiter for a shared
//               WIDTH-bit synchronous up/down counter. A granted run first
//               initialises the counter (clear for up runs, preset to all ones
//               for down runs) and then enables it for exactly the requested
//               number of steps. The final count is compared against the
//               expected value and a one-cycle done pulse goes to the winner.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1      clock, rising edge
//   reset      in   1      asynchronous, active-low reset
//   req        in   2      level run requests, bit i from requester i
//   req_dir    in   2      per-requester direction, 1 = up, 0 = down
//   req_len0   in   WIDTH  step count for requester 0
//   req_len1   in   WIDTH  step count for requester 1
//   gnt        out  2      one-hot grant, SETUP through DONE
//   done       out  2      one-cycle completion pulse to the winner
//   busy       out  1      high whenever not IDLE
//   mismatch   out  1      sticky final-count error flag
//   cnt_clr    out  1      counter synchronous clear
//   cnt_load   out  1      counter synchronous preset (all ones)
//   cnt_mode   out  1      counter direction, 1 = up
//   cnt_en     out  1      counter step enable
//   cnt_value  in   WIDTH  counter output, fed back
// ============================================================================
module updown_count_sched #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [1:0]       req_dir,
    input  logic [WIDTH-1:0] req_len0,
    input  logic [WIDTH-1:0] req_len1,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic             busy,
    output logic             mismatch,
    output logic             cnt_clr,
    output logic             cnt_load,
    output logic             cnt_mode,
    output logic             cnt_en,
    input  logic [WIDTH-1:0] cnt_value
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             win_q, win_d;         // index of the granted requester
    logic             dir_q, dir_d;         // latched direction of the run
    logic [WIDTH-1:0] steps_q, steps_d;     // steps still to be enabled
    logic [WIDTH-1:0] exp_q, exp_d;         // count expected at DONE
    logic             last_q, last_d;       // requester served most recently
    logic             mismatch_q, mismatch_d;

    logic             pick;                 // arbitration result in IDLE
    logic [1:0]       win_onehot;

    // ------------------------------------------------------------------------
    // Round-robin pick. The "last served" pointer resets to requester 1 so
    // that the very first contention after reset goes to requester 0.
    // ------------------------------------------------------------------------
    always_comb begin
        pick = 1'b0;
        unique case (req)
            2'b01:   pick = 1'b0;
            2'b10:   pick = 1'b1;
            2'b11:   pick = ~last_q;
            default: pick = 1'b0;
        endcase
    end

    assign win_onehot = win_q ? 2'b10 : 2'b01;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            win_q      <= 1'b0;
            dir_q      <= 1'b0;
            steps_q    <= '0;
            exp_q      <= '0;
            last_q     <= 1'b1;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            dir_q      <= dir_d;
            steps_q    <= steps_d;
            exp_q      <= exp_d;
            last_q     <= last_d;
            mismatch_q <= mismatch_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        dir_d      = dir_q;
        steps_d    = steps_q;
        exp_d      = exp_q;
        last_d     = last_q;
        mismatch_d = mismatch_q;

        unique case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    // Winner's direction and length are captured here and
                    // held for the whole run, whatever the requester does.
                    win_d   = pick;
                    dir_d   = req_dir[pick];
                    steps_d = pick ? req_len1 : req_len0;
                    state_d = S_SETUP;
                end
            end

            S_SETUP: begin
                // Up runs start from 0 and end at len; down runs start from
                // all ones and end at (all ones - len), which is ~len.
                exp_d   = dir_q ? steps_q : ~steps_q;
                state_d = (steps_q != '0) ? S_RUN : S_DONE;
            end

            S_RUN: begin
                steps_d = steps_q - WIDTH'(1);
                if (steps_q == WIDTH'(1)) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                if (cnt_value != exp_q) begin
                    mismatch_d = 1'b1;
                end
                last_d  = win_q;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs are decoded from the registered state, so an asynchronous
    // reset drives every one of them to 0 immediately.
    // ------------------------------------------------------------------------
    always_comb begin
        gnt      = 2'b00;
        done     = 2'b00;
        busy     = 1'b0;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_mode = 1'b0;
        cnt_en   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
            end
            S_SETUP: begin
                gnt      = win_onehot;
                busy     = 1'b1;
                cnt_mode = dir_q;
                cnt_clr  = dir_q;
                cnt_load = ~dir_q;
            end
            S_RUN: begin
                gnt      = win_onehot;
                busy     = 1'b1;
                cnt_mode = dir_q;
                cnt_en   = 1'b1;
            end
            S_DONE: begin
                gnt      = win_onehot;
                busy     = 1'b1;
                cnt_mode = dir_q;
                done     = win_onehot;
            end
            default: begin
            end
        endcase
    end

    assign mismatch = mismatch_q;

endmodule
`default_nettype wire

// File: tb/tb_updown_count_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_updown_count_sched
// Description : Self-checking bench for updown_count_sched. Hosts a
//               behavioural counter (with an optional dropped-enable fault),
//               a transaction-level timeline model of the controller, a
//               per-cycle compare process, directed scenarios with literal
//               expectations and a randomized two-requester phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_updown_count_sched;

    localparam int W    = 5;
    localparam int MAXV = (1 << W) - 1;

    logic         clk      = 1'b0;
    logic         reset    = 1'b0;
    logic [1:0]   req      = 2'b00;
    logic [1:0]   req_dir  = 2'b00;
    logic [W-1:0] req_len0 = '0;
    logic [W-1:0] req_len1 = '0;
    logic [1:0]   gnt;
    logic [1:0]   done;
    logic         busy;
    logic         mismatch;
    logic         cnt_clr;
    logic         cnt_load;
    logic         cnt_mode;
    logic         cnt_en;
    logic [W-1:0] cnt_value;

    always #5 clk = ~clk;

    updown_count_sched #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_dir   (req_dir),
        .req_len0  (req_len0),
        .req_len1  (req_len1),
        .gnt       (gnt),
        .done      (done),
        .busy      (busy),
        .mismatch  (mismatch),
        .cnt_clr   (cnt_clr),
        .cnt_load  (cnt_load),
        .cnt_mode  (cnt_mode),
        .cnt_en    (cnt_en),
        .cnt_value (cnt_value)
    );

    // ---------------- external counter (with fault hook) ----------------
    logic [W-1:0] cnt_q     = '0;
    int           drop_req  = 0;   // bumped by stimulus to request one dropped enable
    int           drop_done = 0;

    always @(posedge clk) begin
        if (cnt_clr)       cnt_q <= '0;
        else if (cnt_load) cnt_q <= '1;
        else if (cnt_en) begin
            if (drop_req != drop_done) drop_done <= drop_done + 1;
            else                       cnt_q <= cnt_mode ? cnt_q + 1'b1 : cnt_q - 1'b1;
        end
    end
    assign cnt_value = cnt_q;

    // ---------------- checking bookkeeping ----------------
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- timeline model ----------------
    // A run sampled at the edge ending cycle k occupies cycle k+1 (SETUP),
    // cycles k+2..k+1+len (RUN) and cycle k+2+len (DONE).
    int cyc    = 0;
    bit m_act  = 0;
    int m_k    = 0;
    int m_len  = 0;
    bit m_w    = 0;
    bit m_dir  = 0;
    bit m_last = 1;
    bit m_mis  = 0;

    always @(posedge clk or negedge reset) begin
        int ended;
        int m_exp;
        if (!reset) begin
            m_act  = 0;
            m_last = 1;
            m_mis  = 0;
        end else begin
            ended = cyc;
            cyc   = cyc + 1;
            if (m_act && (ended - m_k) == 2 + m_len) begin
                m_exp = m_dir ? m_len : MAXV - m_len;
                if (int'(cnt_value) != m_exp) m_mis = 1;
                m_last = m_w;
                m_act  = 0;
            end else if (!m_act && req != 2'b00) begin
                if (req == 2'b01)      m_w = 0;
                else if (req == 2'b10) m_w = 1;
                else                   m_w = !m_last;
                m_dir = req_dir[m_w];
                m_len = m_w ? int'(req_len1) : int'(req_len0);
                m_k   = ended;
                m_act = 1;
            end
        end
    end

    function automatic logic [1:0] m_done_vec();
        if (m_act && (cyc - m_k) == 2 + m_len) return m_w ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [1:0] eg;
        logic       ec, el, em, ee;
        int         o;
        eg = 2'b00; ec = 0; el = 0; em = 0; ee = 0;
        o  = cyc - m_k;
        if (m_act) begin
            eg = m_w ? 2'b10 : 2'b01;
            if (o == 1) begin
                ec = m_dir; el = !m_dir; em = m_dir;
            end else if (o <= 1 + m_len) begin
                ee = 1; em = m_dir;
            end
        end
        chk("gnt",      32'(gnt),      32'(eg));
        chk("done",     32'(done),     32'(m_done_vec()));
        chk("busy",     32'(busy),     32'(m_act));
        chk("cnt_clr",  32'(cnt_clr),  32'(ec));
        chk("cnt_load", 32'(cnt_load), 32'(el));
        chk("cnt_en",   32'(cnt_en),   32'(ee));
        chk("mismatch", 32'(mismatch), 32'(m_mis));
        if (!m_act || o <= 1 + m_len)
            chk("cnt_mode", 32'(cnt_mode), 32'(em));
    end

    // ---------------- directed helper ----------------
    task automatic run_one(input int i, input bit dir, input int len,
                           output int val, output int lat, output int gc,
                           output int ec, output int lc);
        @(posedge clk); #2;
        req_dir[i] = dir;
        if (i == 0) req_len0 = len[W-1:0];
        else        req_len1 = len[W-1:0];
        req[i] = 1'b1;
        lat = 0; gc = 0; ec = 0; lc = 0; val = -1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            lat++;
            if (gnt[i])   gc++;
            if (cnt_en)   ec++;
            if (cnt_load) lc++;
            if (done[i]) begin
                val = int'(cnt_value);
                break;
            end
        end
        if (val < 0) chk("run_timeout", 0, 1);
        @(posedge clk); #2;
        req[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input string name);
        bit seen;
        seen = 0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            if (done[i]) seen = 1;
        end
        chk(name, 32'(seen), 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int val, lat, gc, ec, lc;
        int wins[4];
        int nd, idle_gaps;
        bit gseen;

        // Reset held low with both requests active.
        reset = 1'b0; req = 2'b11; req_dir = 2'b11; req_len0 = 5; req_len1 = 5;
        repeat (3) @(negedge clk);
        chk("rst_gnt",  32'(gnt),  0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ctl",  32'({done, mismatch, cnt_clr, cnt_load, cnt_mode, cnt_en}), 0);
        @(posedge clk); #2;
        req = 2'b00; reset = 1'b1;

        // Up run, requester 0, len 5.
        run_one(0, 1'b1, 5, val, lat, gc, ec, lc);
        chk("up5_val", val, 5);
        chk("up5_lat", lat, 8);
        chk("up5_gnt_cycles", gc, 7);
        chk("up5_en_cycles", ec, 5);
        chk("up5_mismatch", 32'(mismatch), 0);

        // Down run, requester 1, len 4.
        run_one(1, 1'b0, 4, val, lat, gc, ec, lc);
        chk("dn4_val", val, 27);
        chk("dn4_load_cycles", lc, 1);
        chk("dn4_en_cycles", ec, 4);
        chk("dn4_mismatch", 32'(mismatch), 0);

        // Contention: both held, len 3 each.
        @(posedge clk); #2;
        req_dir = 2'b11; req_len0 = 3; req_len1 = 3; req = 2'b11;
        nd = 0; idle_gaps = 0;
        for (int n = 0; n < 200 && nd < 4; n++) begin
            @(negedge clk);
            if (nd > 0 && gnt == 2'b00) idle_gaps++;
            if (done != 2'b00) begin
                wins[nd] = done[1] ? 1 : 0;
                nd++;
            end
        end
        @(posedge clk); #2;
        req = 2'b00;
        chk("cont_runs", nd, 4);
        chk("cont_w0", wins[0], 0);
        chk("cont_w1", wins[1], 1);
        chk("cont_w2", wins[2], 0);
        chk("cont_w3", wins[3], 1);
        chk("cont_idle_gaps", idle_gaps, 3);

        // Zero length.
        run_one(0, 1'b1, 0, val, lat, gc, ec, lc);
        chk("z_val", val, 0);
        chk("z_lat", lat, 3);
        chk("z_en_cycles", ec, 0);
        chk("z_gnt_cycles", gc, 2);

        // Reset in the middle of a len 10 run.
        @(posedge clk); #2;
        req_dir[0] = 1'b1; req_len0 = 10; req[0] = 1'b1;
        repeat (5) @(negedge clk);
        chk("mid_running", 32'(cnt_en), 1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_gnt",  32'(gnt), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_en",   32'(cnt_en), 0);
        req[1] = 1'b1; req_dir[1] = 1'b0; req_len1 = 2;
        repeat (2) begin
            @(negedge clk);
            chk("mid_rst_nodone", 32'(done), 0);
        end
        @(posedge clk); #2;
        reset = 1'b1;
        gseen = 0;
        for (int n = 0; n < 10 && !gseen; n++) begin
            @(negedge clk);
            if (gnt != 2'b00) begin
                gseen = 1;
                chk("post_rst_winner", 32'(gnt), 1);
            end
        end
        chk("post_rst_granted", 32'(gseen), 1);
        wait_done(0, "post_rst_done0");
        @(posedge clk); #2 req[0] = 1'b0;
        wait_done(1, "post_rst_done1");
        @(posedge clk); #2 req[1] = 1'b0;

        // Fault: one enable dropped during an up run of len 6.
        drop_req = drop_req + 1;
        run_one(0, 1'b1, 6, val, lat, gc, ec, lc);
        chk("fault_val", val, 5);
        @(negedge clk);
        chk("fault_mismatch", 32'(mismatch), 1);
        run_one(1, 1'b0, 2, val, lat, gc, ec, lc);
        chk("good_after_fault_val", val, 29);
        chk("mismatch_sticky", 32'(mismatch), 1);
        @(posedge clk); #2 reset = 1'b0;
        #1 chk("mismatch_cleared", 32'(mismatch), 0);
        @(posedge clk); #2 reset = 1'b1;

        // Randomized phase: two independent requesters.
        for (int c = 0; c < 3000; c++) begin
            logic [1:0] md;
            @(posedge clk); #2;
            md = m_done_vec();
            for (int i = 0; i < 2; i++) begin
                if (md[i]) begin
                    req[i] = 1'b0;
                end else if (!req[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        int l;
                        l = ($urandom_range(0, 9) == 0) ? MAXV : int'($urandom_range(0, 6));
                        req_dir[i] = 1'($urandom_range(0, 1));
                        if (i == 0) req_len0 = l[W-1:0];
                        else        req_len1 = l[W-1:0];
                        req[i] = 1'b1;
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    int l;
                    l = int'($urandom_range(0, MAXV));
                    req_dir[i] = 1'($urandom_range(0, 1));
                    if (i == 0) req_len0 = l[W-1:0];
                    else        req_len1 = l[W-1:0];
                end else if ($urandom_range(0, 39) == 0) begin
                    req[i] = 1'b0;
                end
            end
            if ($urandom_range(0, 249) == 0) drop_req = drop_req + 1;
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b0;
                @(posedge clk); #2;
                reset = 1'b1;
            end
        end

        req = 2'b00;
        repeat (40) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
